// File: rtl/capture_ctrl.sv
// capture_ctrl: capture sequencer for the logic-analyzer sample RAM.
// Fills the circular buffer with pre-trigger samples, arms the trigger
// block, counts post-trigger samples and reports completion.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no capture in progress; no writes, waddr holds
// FILL  | storing the pre-trigger samples
// ARMED | pre-trigger history full; waiting for triggered
// POST  | counting trig_eff post-trigger writes
// DONE  | capture complete; waiting for the next run
module capture_ctrl #(
   parameter int DEPTH  = 384,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [ADDR_W-1:0] trig_pos,
   input  logic              wrt_smpl,
   input  logic              triggered,
   input  logic              clr_capture_done,
   output logic              armed,
   output logic              set_capture_done,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [ADDR_W-1:0] trace_end,
   output logic              capture_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      ARMED,
      POST,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [ADDR_W-1:0] trace_end_q, trace_end_d;
   logic [ADDR_W-1:0] trig_eff_q, trig_eff_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   pre_cnt_q, pre_cnt_d;
   logic              set_done_q, set_done_d;
   logic              capture_done_q, capture_done_d;

   logic              capturing;
   logic              finish;
   logic              done_evt;
   logic [ADDR_W-1:0] waddr_inc;
   logic [ADDR_W-1:0] waddr_prev;
   logic [ADDR_W-1:0] trig_clamp;
   logic [ADDR_W:0]   cnt_inc;

   // Write qualification and the modulo-DEPTH address arithmetic.
   always_comb begin
      capturing  = (state_q == FILL) || (state_q == ARMED) || (state_q == POST);
      we         = wrt_smpl && capturing;
      waddr_inc  = (waddr_q == LAST_ADDR) ? '0 : waddr_q + ADDR_W'(1);
      waddr_prev = (waddr_q == '0) ? LAST_ADDR : waddr_q - ADDR_W'(1);
      cnt_inc    = cnt_q + (ADDR_W + 1)'(1);
      // Clamp keeps at least one pre-trigger sample in the buffer.
      trig_clamp = (trig_pos > LAST_ADDR) ? LAST_ADDR : trig_pos;
   end

   // Next-state, counters and completion bookkeeping; run overrides all.
   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      cnt_d       = cnt_q;
      trig_eff_d  = trig_eff_q;
      pre_cnt_d   = pre_cnt_q;
      trace_end_d = trace_end_q;
      finish      = 1'b0;

      if (we) begin
         waddr_d = waddr_inc;
      end

      case (state_q)
         FILL: begin
            if (we) begin
               cnt_d = cnt_inc;
               if (cnt_inc == pre_cnt_q) begin
                  state_d = ARMED;
               end
            end
         end
         ARMED: begin
            // A write coinciding with the trigger is a pre-trigger sample.
            if (triggered) begin
               if (trig_eff_q == '0) begin
                  finish  = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = POST;
               end
            end
         end
         POST: begin
            if (we) begin
               cnt_d = cnt_inc;
               if (cnt_inc == {1'b0, trig_eff_q}) begin
                  finish  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         default: ;
      endcase

      done_evt = finish && !run;

      // Without a write on the finishing cycle, the last sample sits one behind waddr.
      if (done_evt) begin
         trace_end_d = we ? waddr_q : waddr_prev;
      end

      if (run) begin
         state_d    = FILL;
         waddr_d    = '0;
         cnt_d      = '0;
         trig_eff_d = trig_clamp;
         pre_cnt_d  = DEPTH_CNT - {1'b0, trig_clamp};
      end

      set_done_d = done_evt;

      // Setting wins over a coincident clear.
      if (done_evt) begin
         capture_done_d = 1'b1;
      end else if (run || clr_capture_done) begin
         capture_done_d = 1'b0;
      end else begin
         capture_done_d = capture_done_q;
      end
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         waddr_q        <= '0;
         cnt_q          <= '0;
         trig_eff_q     <= '0;
         pre_cnt_q      <= '0;
         trace_end_q    <= '0;
         set_done_q     <= 1'b0;
         capture_done_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         waddr_q        <= waddr_d;
         cnt_q          <= cnt_d;
         trig_eff_q     <= trig_eff_d;
         pre_cnt_q      <= pre_cnt_d;
         trace_end_q    <= trace_end_d;
         set_done_q     <= set_done_d;
         capture_done_q <= capture_done_d;
      end
   end

   // Output drive.
   always_comb begin
      armed            = (state_q == ARMED);
      set_capture_done = set_done_q;
      waddr            = waddr_q;
      trace_end        = trace_end_q;
      capture_done     = capture_done_q;
   end

endmodule
